// File: rtl/stack_burst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : stack_burst_seq
//  Purpose  : Multi-register stack transfer sequencer. Walks the set bits of a
//             push/pop register mask and issues one SS-relative stack memory
//             transfer per set bit, producing the final SP.
//             - Push order is lowest set bit first; SP is pre-decremented.
//             - Pop order is highest set bit first; SP is post-incremented.
//  Ports    :
//    clk, reset              clock, asynchronous active-high reset
//    start, dir, mask, sp_in operation request (latched in IDLE)
//    busy, done, sp_out, sp_we  status, completion pulse, SP result/commit
//    reg_sel, reg_rdata      register slot select and its current value
//    reg_wdata, reg_we       popped value and its write strobe
//    mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack  stack bus
//  Revision : 1.0  initial release
// ============================================================================
module stack_burst_seq #(
  parameter int MASK_W = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [MASK_W-1:0] DISC_MASK = MASK_W'(16'h0020)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       dir,
  input  logic [MASK_W-1:0]          mask,
  input  logic [ADDR_W-1:0]          sp_in,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          sp_out,
  output logic                       sp_we,
  output logic [$clog2(MASK_W)-1:0]  reg_sel,
  input  logic [DATA_W-1:0]          reg_rdata,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic                       reg_we,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack
);

  localparam int SEL_W = $clog2(MASK_W);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t              state;
  logic                dir_q;
  logic [MASK_W-1:0]   rem;       // slots still to transfer
  logic [SEL_W-1:0]    pick;      // next slot to transfer
  logic [MASK_W-1:0]   pick_bit;

  // Push walks upward (lowest set bit), pop walks downward (highest set bit).
  // The last assignment in each loop wins, giving the required priority.
  always_comb begin
    pick = '0;
    if (dir_q) begin
      for (int i = 0; i < MASK_W; i++)
        if (rem[i]) pick = SEL_W'(i);
    end else begin
      for (int i = MASK_W - 1; i >= 0; i--)
        if (rem[i]) pick = SEL_W'(i);
    end
    pick_bit = MASK_W'(1) << pick;
  end

  assign busy      = (state != IDLE);
  assign mem_wdata = (mem_req && mem_we) ? reg_rdata : '0;

  // done/sp_we/reg_we are registered on the edge that enters SCAN, so they are
  // high during that SCAN cycle and reg_sel still names the popped slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      rem       <= '0;
      sp_out    <= '0;
      done      <= 1'b0;
      sp_we     <= 1'b0;
      reg_sel   <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      done   <= 1'b0;
      sp_we  <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_q  <= dir;
            rem    <= mask;
            sp_out <= sp_in;
            done   <= (mask == '0);
            sp_we  <= (mask == '0);
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (rem == '0) begin
            state <= IDLE;
          end else begin
            reg_sel  <= pick;
            mem_addr <= dir_q ? sp_out : sp_out - STEP;
            rem      <= rem & ~pick_bit;
            mem_req  <= 1'b1;
            mem_we   <= ~dir_q;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            sp_out  <= dir_q ? sp_out + STEP : sp_out - STEP;
            if (dir_q) begin
              reg_wdata <= mem_rdata;
              reg_we    <= ~DISC_MASK[reg_sel];
            end
            // rem already excludes the slot just transferred.
            done  <= (rem == '0);
            sp_we <= (rem == '0);
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_burst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_burst_seq
//  Purpose  : Self-checking bench for stack_burst_seq against a transfer-list
//             reference model (expected slot order, addresses, data, final SP).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stack_burst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: default parameters ----------------
  logic        reset, start, dir;
  logic [15:0] mask, sp_in;
  logic        busy, done, sp_we, reg_we, mem_req, mem_we, mem_ack;
  logic [15:0] sp_out, reg_rdata, reg_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  reg_sel;

  logic [15:0] regs [16];
  logic [15:0] mem [logic [15:0]];
  assign reg_rdata = regs[reg_sel];

  stack_burst_seq dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .mask(mask),
    .sp_in(sp_in), .busy(busy), .done(done), .sp_out(sp_out), .sp_we(sp_we),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ---------------- DUT 1: 8 slots, 32-bit data ----------------
  logic        start1, busy1, done1, sp_we1, reg_we1, mem_req1, mem_we1;
  logic [7:0]  mask1;
  logic [15:0] sp_in1, sp_out1, mem_addr1;
  logic [2:0]  reg_sel1;
  logic [31:0] reg_rdata1, reg_wdata1, mem_wdata1;
  assign reg_rdata1 = 32'hA5A5_0000 | 32'(reg_sel1);

  stack_burst_seq #(.MASK_W(8), .ADDR_W(16), .DATA_W(32), .DISC_MASK(8'h20)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .dir(1'b0), .mask(mask1),
    .sp_in(sp_in1), .busy(busy1), .done(done1), .sp_out(sp_out1), .sp_we(sp_we1),
    .reg_sel(reg_sel1), .reg_rdata(reg_rdata1), .reg_wdata(reg_wdata1),
    .reg_we(reg_we1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(32'h0), .mem_ack(1'b1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [15:0] data;
  } xfer_t;

  // One complete operation on DUT 0. Ack latency per transfer is drawn from
  // [minw, maxw]; completion latency is only checked when every ack is 0-wait.
  task automatic run_op(input bit d, input logic [15:0] m, input logic [15:0] sp,
                        input int minw, input int maxw);
    xfer_t exp_q[$];
    xfer_t wb_q[$];
    xfer_t e, w;
    logic [15:0] cur = sp;
    logic [15:0] hold_addr;
    logic [3:0]  hold_sel;
    int n, idx = 0, cyc = 0, wt = 0;
    bit pending = 0, finished = 0;

    // Reference model: transfer list and final SP from the mask rules.
    if (!d) begin
      for (int i = 0; i < 16; i++)
        if (m[i]) begin
          cur = cur - 16'd2;
          exp_q.push_back('{sel: 4'(i), addr: cur, data: regs[i]});
        end
    end else begin
      for (int i = 15; i >= 0; i--)
        if (m[i]) begin
          if (!mem.exists(cur)) mem[cur] = 16'($urandom);
          e = '{sel: 4'(i), addr: cur, data: mem[cur]};
          exp_q.push_back(e);
          if (i != 5) wb_q.push_back(e);
          cur = cur + 16'd2;
        end
    end
    n = exp_q.size();

    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1; dir = d; mask = m; sp_in = sp; mem_ack = 0;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (reg_we) begin
        if (wb_q.size() == 0) check("reg_we_extra", 1, 0);
        else begin
          w = wb_q.pop_front();
          check("wb_sel", reg_sel, w.sel);
          check("wb_data", reg_wdata, w.data);
          regs[w.sel] = w.data;
        end
      end
      if (done) begin
        if (maxw == 0) check("done_cycle", cyc, 2 * n + 1);
        check("sp_out", sp_out, cur);
        check("sp_we", sp_we, 1);
        check("xfer_count", idx, n);
        check("wb_left", wb_q.size(), 0);
        check("req_at_done", mem_req, 0);
        finished = 1;
      end
      // Random start/operands while busy must have no effect.
      mem_ack = 0;
      mem_rdata = 16'($urandom);
      start = finished ? 1'b0 : 1'($urandom_range(0, 1));
      dir = 1'($urandom); mask = 16'($urandom); sp_in = 16'($urandom);
      if (mem_req) begin
        if (!pending) begin
          if (idx >= n) begin
            check("req_extra", 1, 0);
            e = '{sel: 4'd0, addr: 16'd0, data: 16'd0};
          end else begin
            e = exp_q[idx];
            check("req_sel", reg_sel, e.sel);
            check("req_addr", mem_addr, e.addr);
            check("req_we", mem_we, !d);
            if (!d) check("req_wdata", mem_wdata, e.data);
          end
          pending = 1;
          wt = $urandom_range(maxw, minw);
          hold_addr = mem_addr;
          hold_sel = reg_sel;
        end else begin
          check("req_hold", {mem_addr, reg_sel}, {hold_addr, hold_sel});
        end
        if (wt == 0) begin
          mem_ack = 1;
          if (d) mem_rdata = e.data;
          else mem[e.addr] = e.data;
          idx++;
          pending = 0;
        end else begin
          wt--;
        end
      end
    end
    if (!finished) check("timeout", 0, 1);
    start = 0;
    mem_ack = 0;
  endtask

  task automatic reset_mid_req();
    int cyc = 0;
    @(negedge clk);
    start = 1; dir = 0; mask = 16'h000F; sp_in = 16'h0100; mem_ack = 0;
    @(negedge clk);
    start = 0;
    while (!mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_req", mem_req, 1);
    reset = 1;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sp_we", sp_we, 0);
    check("rst_reg_we", reg_we, 0);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic run_wide();
    logic [15:0] addrs[$];
    logic [31:0] datas[$];
    int cyc = 0;
    bit finished = 0;
    @(negedge clk);
    start1 = 1; mask1 = 8'h81; sp_in1 = 16'h0040;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start1 = 0;
      if (mem_req1) begin
        addrs.push_back(mem_addr1);
        datas.push_back(mem_wdata1);
      end
      if (done1) begin
        check("w_done_cycle", cyc, 5);
        check("w_sp_out", sp_out1, 16'h0038);
        check("w_nreq", addrs.size(), 2);
        finished = 1;
      end
    end
    if (!finished) check("w_timeout", 0, 1);
    if (addrs.size() == 2) begin
      check("w_addr0", addrs[0], 16'h003C);
      check("w_addr1", addrs[1], 16'h0038);
      check("w_data0", datas[0], 32'hA5A5_0000);
      check("w_data1", datas[1], 32'hA5A5_0007);
    end
  endtask

  initial begin
    reset = 1; start = 0; dir = 0; mask = '0; sp_in = '0;
    mem_ack = 0; mem_rdata = '0;
    start1 = 0; mask1 = '0; sp_in1 = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    @(negedge clk);
    @(negedge clk);
    check("rst0_busy", busy, 0);
    check("rst0_done", done, 0);
    check("rst0_req", mem_req, 0);
    check("rst0_sp", sp_out, 0);
    check("rst0_sel", reg_sel, 0);
    reset = 0;

    run_op(0, 16'h000F, 16'h0100, 0, 0);
    run_op(1, 16'h00FF, 16'h00F0, 0, 0);
    run_op(0, 16'h0001, 16'h0000, 0, 0);
    run_op(1, 16'h0001, 16'hFFFE, 0, 0);
    run_op(0, 16'h0000, 16'h1234, 0, 0);
    run_op(1, 16'h0003, 16'h2000, 5, 5);
    reset_mid_req();
    run_op(0, 16'h8421, 16'h0100, 0, 0);

    for (int k = 0; k < 25; k++)
      run_op(1'($urandom), 16'($urandom), 16'($urandom) & 16'hFFFE, 0,
             $urandom_range(0, 3));

    run_wide();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
